// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - redirect/stall request and fetch-control bundle for pc_sequencer
interface pc_sequencer_if #(
    parameter int CNT_W = 16
);
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              stall;
    logic [31:0]       pc;
    logic              fd_flush;
    logic              dx_flush;
    logic              busy;
    logic [CNT_W-1:0]  redirect_count;

    modport master (
        output redirect_valid, redirect_pc, stall,
        input  pc, fd_flush, dx_flush, busy, redirect_count
    );

    modport slave (
        input  redirect_valid, redirect_pc, stall,
        output pc, fd_flush, dx_flush, busy, redirect_count
    );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch PC sequencer with stall-deferred redirects and pipeline flush
module pc_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 2,
    parameter int          CNT_W        = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    pc_sequencer_if.slave bus
);
    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_PEND  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    localparam logic [3:0]       FLUSH_LOAD = 4'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    logic [1:0]       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      pend_q, pend_d;
    logic [3:0]       cd_q, cd_d;
    logic [CNT_W-1:0] cnt_q;
    logic             enter_flush;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_d      = pend_q;
        cd_d        = cd_q;
        enter_flush = 1'b0;
        case (state_q)
            S_RUN: begin
                if (bus.stall) begin
                    if (bus.redirect_valid) begin
                        pend_d  = bus.redirect_pc;
                        state_d = S_PEND;
                    end
                end else if (bus.redirect_valid) begin
                    pc_d        = bus.redirect_pc;
                    enter_flush = 1'b1;
                end else begin
                    pc_d = pc_q + 32'd1;
                end
            end
            S_PEND: begin
                if (bus.stall) begin
                    if (bus.redirect_valid) begin
                        pend_d = bus.redirect_pc;
                    end
                end else begin
                    // A fresh request on the release cycle is younger than the pending one.
                    pc_d        = bus.redirect_valid ? bus.redirect_pc : pend_q;
                    enter_flush = 1'b1;
                end
            end
            S_FLUSH: begin
                // Redirects seen here come from wrong-path instructions and are dropped.
                if (!bus.stall) begin
                    pc_d = pc_q + 32'd1;
                    cd_d = cd_q - 4'd1;
                    if (cd_q == 4'd1) begin
                        state_d = S_RUN;
                    end
                end
            end
            default: state_d = S_RUN;
        endcase
        if (enter_flush) begin
            state_d = S_FLUSH;
            cd_d    = FLUSH_LOAD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            pc_q    <= RESET_PC;
            pend_q  <= 32'd0;
            cd_q    <= 4'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            cd_q    <= cd_d;
            if (enter_flush && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.pc             = pc_q;
    assign bus.fd_flush       = (state_q == S_FLUSH);
    assign bus.dx_flush       = (state_q == S_FLUSH);
    assign bus.busy           = (state_q == S_PEND) || (state_q == S_FLUSH);
    assign bus.redirect_count = cnt_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - vector table and scoreboard bench for pc_sequencer
module tb_pc_sequencer;
    typedef struct {
        bit          stall;
        bit          rv;
        logic [31:0] rpc;
        logic [31:0] pc;
        bit          flush;
        bit          busy;
        int          cnt;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        bit          flush;
        bit          busy;
        int          cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    vec_t vecs[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    pc_sequencer_if #(.CNT_W(16)) bus1 ();
    pc_sequencer_if #(.CNT_W(2))  bus2 ();

    pc_sequencer #(.RESET_PC(32'h0), .FLUSH_CYCLES(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave)
    );

    pc_sequencer #(.RESET_PC(32'h100), .FLUSH_CYCLES(1), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit s, bit r, logic [31:0] rpc, logic [31:0] p, bit f, bit b, int c);
        vec_t v;
        v.stall = s; v.rv = r; v.rpc = rpc; v.pc = p; v.flush = f; v.busy = b; v.cnt = c;
        return v;
    endfunction

    task automatic check_dut1(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = sb.pop_front();
        chk({tag, ".pc"},       bus1.pc,                    e.pc);
        chk({tag, ".fd_flush"}, 32'(bus1.fd_flush),         32'(e.flush));
        chk({tag, ".dx_flush"}, 32'(bus1.dx_flush),         32'(e.flush));
        chk({tag, ".busy"},     32'(bus1.busy),             32'(e.busy));
        chk({tag, ".count"},    32'(bus1.redirect_count),   32'(e.cnt));
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are checked 1 unit after the next one.
    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        bus1.stall          = v.stall;
        bus1.redirect_valid = v.rv;
        bus1.redirect_pc    = v.rpc;
        e.pc = v.pc; e.flush = v.flush; e.busy = v.busy; e.cnt = v.cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_dut1(tag);
    endtask

    initial begin
        bus1.stall = 1'b0; bus1.redirect_valid = 1'b0; bus1.redirect_pc = 32'd0;
        bus2.stall = 1'b0; bus2.redirect_valid = 1'b0; bus2.redirect_pc = 32'd0;

        for (int i = 1; i <= 10; i++) vecs.push_back(mk(0, 0, 0, 32'(i), 0, 0, 0));
        vecs.push_back(mk(0, 1, 100, 100, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0,   101, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0,   102, 0, 0, 1));
        vecs.push_back(mk(0, 1, 18,  18,  1, 1, 2));
        vecs.push_back(mk(0, 0, 0,   19,  1, 1, 2));
        vecs.push_back(mk(0, 0, 0,   20,  0, 0, 2));
        vecs.push_back(mk(1, 1, 50,  20,  0, 1, 2));
        vecs.push_back(mk(1, 1, 60,  20,  0, 1, 2));
        vecs.push_back(mk(1, 0, 0,   20,  0, 1, 2));
        vecs.push_back(mk(1, 0, 0,   20,  0, 1, 2));
        vecs.push_back(mk(0, 0, 0,   60,  1, 1, 3));
        vecs.push_back(mk(1, 0, 0,   60,  1, 1, 3));
        vecs.push_back(mk(1, 1, 7,   60,  1, 1, 3));
        vecs.push_back(mk(0, 1, 7,   61,  1, 1, 3));
        vecs.push_back(mk(0, 0, 0,   62,  0, 0, 3));
        vecs.push_back(mk(0, 1, 62,  62,  1, 1, 4));
        vecs.push_back(mk(0, 0, 0,   63,  1, 1, 4));
        vecs.push_back(mk(0, 0, 0,   64,  0, 0, 4));
        vecs.push_back(mk(0, 1, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 1, 1, 5));
        vecs.push_back(mk(0, 0, 0,   32'hFFFF_FFFE, 1, 1, 5));
        vecs.push_back(mk(0, 0, 0,   32'hFFFF_FFFF, 0, 0, 5));
        vecs.push_back(mk(0, 0, 0,   0,   0, 0, 5));
        vecs.push_back(mk(1, 1, 300, 0,   0, 1, 5));
        vecs.push_back(mk(0, 1, 400, 400, 1, 1, 6));
        vecs.push_back(mk(0, 0, 0,   401, 1, 1, 6));
        vecs.push_back(mk(0, 0, 0,   402, 0, 0, 6));
        vecs.push_back(mk(1, 1, 77,  402, 0, 1, 6));

        repeat (2) @(posedge clk);
        #1;
        chk("reset.pc",    bus1.pc,                  32'h0);
        chk("reset.flush", 32'(bus1.fd_flush | bus1.dx_flush), 32'd0);
        chk("reset.busy",  32'(bus1.busy),           32'd0);
        chk("reset.count", 32'(bus1.redirect_count), 32'd0);
        chk("reset2.pc",   bus2.pc,                  32'h100);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

        // Asynchronous reset while a redirect to 77 is pending.
        bus1.stall = 1'b1; bus1.redirect_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst.pc",    bus1.pc,                  32'h0);
        chk("async_rst.busy",  32'(bus1.busy),           32'd0);
        chk("async_rst.flush", 32'(bus1.fd_flush),       32'd0);
        chk("async_rst.count", 32'(bus1.redirect_count), 32'd0);
        chk("async_rst2.pc",   bus2.pc,                  32'h100);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply(mk(0, 0, 0, 1, 0, 0, 0), "post_rst0");
        apply(mk(0, 0, 0, 2, 0, 0, 0), "post_rst1");

        // Saturating 2-bit counter and single-cycle flush on the second instance.
        for (int i = 0; i < 5; i++) begin
            bus2.redirect_valid = 1'b1;
            bus2.redirect_pc    = 32'(1000 + i);
            @(posedge clk);
            #1;
            chk($sformatf("sat%0d.pc", i),    bus2.pc,                  32'(1000 + i));
            chk($sformatf("sat%0d.flush", i), 32'(bus2.fd_flush),       32'd1);
            chk($sformatf("sat%0d.count", i), 32'(bus2.redirect_count), 32'((i < 3) ? i + 1 : 3));
            bus2.redirect_valid = 1'b0;
            @(posedge clk);
            #1;
            chk($sformatf("sat%0d.unflush", i), 32'(bus2.fd_flush),     32'd0);
        end

        if (sb.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: fetch PC value loaded on reset.
REQ-002 Parameter FLUSH_CYCLES, default 2: number of unstalled cycles flush outputs stay asserted after a redirect; legal range 1..15.
REQ-003 Parameter CNT_W, default 16: width of redirect statistics counter.
REQ-004 clock  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-006 redirect_valid  input  1  execute stage requests PC redirect (branch taken, j/jal, jr, bex).
REQ-007 redirect_pc  input  32  redirect target; sampled only when redirect_valid=1.
REQ-008 stall  input  1  hazard/multdiv stall; PC and flush countdown hold while 1.
REQ-009 pc  output  32  current fetch PC, word-addressed.
REQ-010 fd_flush  output  1  inject bubble into F/D latch this cycle.
REQ-011 dx_flush  output  1  inject bubble into D/X latch this cycle.
REQ-012 busy  output  1  high in PEND or FLUSH state.
REQ-013 redirect_count  output  CNT_W  number of redirects applied, saturating.

Function
REQ-014 Block SHALL implement a three-state FSM: RUN, PEND, FLUSH, all outputs registered or decoded from registered state.
REQ-015 RUN, redirect_valid=0, stall=0: pc SHALL increment by 1 (mod 2^32, 32'hFFFF_FFFF wraps to 0).
REQ-016 RUN, stall=1, redirect_valid=0: pc SHALL hold; state stays RUN.
REQ-017 RUN, redirect_valid=1, stall=0: next cycle pc SHALL equal redirect_pc, state FLUSH, flush countdown loaded with FLUSH_CYCLES.
REQ-018 RUN, redirect_valid=1, stall=1: redirect_pc SHALL be captured into pending register, pc holds, state PEND.
REQ-019 PEND, stall=1: pc SHALL hold; redirect_valid=1 SHALL overwrite pending register (latest request wins).
REQ-020 PEND, stall=0: next pc SHALL be redirect_pc if redirect_valid=1 that cycle, else pending register; state FLUSH, countdown loaded with FLUSH_CYCLES.
REQ-021 fd_flush and dx_flush SHALL both equal 1 exactly when state is FLUSH, 0 otherwise.
REQ-022 FLUSH, stall=0: pc SHALL increment by 1 and countdown decrement; when countdown reaches 1 and decrements, state returns to RUN next cycle.
REQ-023 FLUSH, stall=1: pc and countdown SHALL hold; flush outputs stay 1.
REQ-024 FLUSH: redirect_valid SHALL be ignored (wrong-path instruction) and not counted.
REQ-025 Redirect latency: redirect accepted with stall=0 in RUN SHALL appear on pc at the next rising edge (1 cycle); flush outputs asserted for exactly FLUSH_CYCLES unstalled cycles starting that same edge.
REQ-026 redirect_count SHALL increment by 1 on each transition into FLUSH, saturate at all-ones, never wrap.
REQ-027 busy SHALL equal 1 in PEND or FLUSH.
REQ-028 redirect_pc equal to current pc SHALL be treated as a normal redirect (flush still performed, counted).

Reset
REQ-029 reset=0 SHALL asynchronously set pc=RESET_PC, state RUN, countdown 0, pending register 0, redirect_count 0, fd_flush=dx_flush=busy=0.
REQ-030 Reset asserted mid-PEND or mid-FLUSH SHALL discard pending redirect and flush; first cycle after release behaves as RUN from RESET_PC.
REQ-031 Reset release SHALL take effect on the first rising edge with reset=1; that edge SHALL apply REQ-015..018 rules.

Verification
REQ-032 Reset release, no stall/redirect, 5 cycles -> pc 0,1,2,3,4,5; flushes 0; redirect_count 0.
REQ-033 pc=10, redirect_valid=1 redirect_pc=100 one cycle, stall=0 -> pc 100,101,102; fd_flush/dx_flush high exactly 2 cycles (pc=100,101); redirect_count=1.
REQ-034 pc=20, stall=1 with redirect_pc=50, then redirect_pc=60 while stall held 3 cycles, stall drops -> pc holds 20 during stall, then 60; PEND visible via busy; count=1.
REQ-035 FLUSH with stall=1 for 2 cycles mid-flush -> pc and flush hold; total flush-high cycles = 2 unstalled + 2 stalled; redirect_valid=1 during FLUSH ignored, count unchanged.
REQ-036 Saturation and wrap: CNT_W=2, 5 redirects -> redirect_count stops at 3; pc=32'hFFFF_FFFF free-running -> next pc 0.
REQ-037 Reset asserted asynchronously in PEND (pending=77) -> pc=RESET_PC immediately, busy=0; after release no jump to 77.
